// File: rtl/sram_march_bist_if.sv
// SRAM BIST port bundle: engine drives EN/MEN/WEN/REN/ADDR/DIN/BM, macro returns DOUT.
// Purely combinational wiring; no latency, no backpressure.
interface sram_march_bist_if;
    logic        bist_en_o;
    logic        bist_men_o;
    logic        bist_wen_o;
    logic        bist_ren_o;
    logic [8:0]  bist_addr_o;
    logic [31:0] bist_din_o;
    logic [31:0] bist_bm_o;
    logic [31:0] bist_dout_i;

    modport master (
        output bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
        output bist_addr_o, bist_din_o, bist_bm_o,
        input  bist_dout_i
    );

    modport slave (
        input  bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
        input  bist_addr_o, bist_din_o, bist_bm_o,
        output bist_dout_i
    );
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST over a 512x32 SRAM: 5120 gap-free ops, done at start edge + 5121.
// Read data is compared one cycle after the read; start_i is ignored while busy, no backpressure.
module sram_march_bist (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic               fail_o,
    output logic [8:0]         fail_addr_o,
    output logic [2:0]         fail_elem_o,
    output logic [31:0]        fail_bits_o,
    sram_march_bist_if.master  sram
);
    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  addr_q;
    logic        phase_q;
    logic        start_acc, in_march, two_op, descend, at_addr_end, elem_last;
    logic        is_rd, is_wr, wr_bit, rd_bit;
    logic [2:0]  elem_num;
    logic        rd_vld_q;
    logic [31:0] exp_q;
    logic [8:0]  rd_addr_q;
    logic [2:0]  rd_elem_q;
    logic [31:0] miscmp;

    always_comb begin
        start_acc   = start_i && (state_q == S_IDLE || state_q == S_DONE);
        in_march    = state_q inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5};
        two_op      = state_q inside {S_M1, S_M2, S_M3, S_M4};
        descend     = state_q inside {S_M3, S_M4};
        // phase 0 is the read, phase 1 the write, for the two-op elements
        at_addr_end = !two_op || phase_q;
        elem_last   = in_march && at_addr_end && (addr_q == (descend ? 9'd0 : 9'd511));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_i)   state_d = S_M0;
            S_M0:           if (elem_last) state_d = S_M1;
            S_M1:           if (elem_last) state_d = S_M2;
            S_M2:           if (elem_last) state_d = S_M3;
            S_M3:           if (elem_last) state_d = S_M4;
            S_M4:           if (elem_last) state_d = S_M5;
            S_M5:           if (elem_last) state_d = S_DRAIN;
            S_DRAIN:                       state_d = S_DONE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // Reload on the element's final op so the next element starts without a bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            phase_q <= 1'b0;
        end else if (start_acc) begin
            addr_q  <= '0;
            phase_q <= 1'b0;
        end else if (in_march) begin
            if (!at_addr_end) begin
                phase_q <= 1'b1;
            end else begin
                phase_q <= 1'b0;
                if (elem_last)
                    addr_q <= (state_q == S_M2 || state_q == S_M3) ? 9'd511 : 9'd0;
                else if (descend)
                    addr_q <= addr_q - 9'd1;
                else
                    addr_q <= addr_q + 9'd1;
            end
        end
    end

    always_comb begin
        is_rd    = in_march && (state_q == S_M5 || (two_op && !phase_q));
        is_wr    = in_march && !is_rd;
        wr_bit   = state_q inside {S_M1, S_M3};
        rd_bit   = state_q inside {S_M2, S_M4};
        elem_num = 3'd0;
        case (state_q)
            S_M1:    elem_num = 3'd1;
            S_M2:    elem_num = 3'd2;
            S_M3:    elem_num = 3'd3;
            S_M4:    elem_num = 3'd4;
            S_M5:    elem_num = 3'd5;
            default: elem_num = 3'd0;
        endcase
        busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
        done_o           = (state_q == S_DONE);
        pass_o           = done_o && !fail_o;
        sram.bist_en_o   = busy_o;
        sram.bist_men_o  = in_march;
        sram.bist_wen_o  = is_wr;
        sram.bist_ren_o  = is_rd;
        sram.bist_addr_o = in_march ? addr_q : 9'd0;
        sram.bist_din_o  = is_wr ? {32{wr_bit}} : 32'd0;
        sram.bist_bm_o   = is_wr ? 32'hFFFF_FFFF : 32'd0;
    end

    assign miscmp = sram.bist_dout_i ^ exp_q;

    // Read context travels one stage so it lines up with the returning DOUT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_q    <= 1'b0;
            exp_q       <= '0;
            rd_addr_q   <= '0;
            rd_elem_q   <= '0;
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= '0;
            fail_bits_o <= '0;
        end else begin
            rd_vld_q  <= is_rd;
            exp_q     <= {32{rd_bit}};
            rd_addr_q <= addr_q;
            rd_elem_q <= elem_num;
            if (start_acc) begin
                fail_o      <= 1'b0;
                fail_addr_o <= '0;
                fail_elem_o <= '0;
                fail_bits_o <= '0;
            end else if (rd_vld_q && (miscmp != 32'd0)) begin
                if (!fail_o) begin
                    fail_addr_o <= rd_addr_q;
                    fail_elem_o <= rd_elem_q;
                    fail_bits_o <= miscmp;
                end
                fail_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: directed runs against a fault-injectable SRAM model,
// expected results queued at launch and checked by an independent monitor.
module tb_sram_march_bist;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        busy_o, done_o, pass_o, fail_o;
    logic [8:0]  fail_addr_o;
    logic [2:0]  fail_elem_o;
    logic [31:0] fail_bits_o;

    sram_march_bist_if bus();

    sram_march_bist dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .fail_elem_o (fail_elem_o),
        .fail_bits_o (fail_bits_o),
        .sram        (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        pass;
        logic        fail;
        logic [8:0]  addr;
        logic [2:0]  elem;
        logic [31:0] bits;
    } res_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic        fail;
        logic [8:0]  faddr;
        logic [2:0]  felem;
        logic [31:0] fbits;
        logic        bus_zero;
    } probe_t;

    res_t   res_q[$];
    probe_t probe_q[$];

    int   vectors = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   e0      = 0;
    logic run_active = 1'b0;
    int   fault_mode = 0;

    // SRAM model: synchronous read, DOUT valid the cycle after the read is sampled.
    logic [31:0] mem [512];

    function automatic logic [31:0] faulty(input logic [31:0] d, input logic [8:0] a);
        logic [31:0] r;
        r = d;
        if (fault_mode == 1 && a == 9'h1A5) r[7] = 1'b1;
        if (fault_mode == 2 && a == 9'h000) r[31] = 1'b0;
        return r;
    endfunction

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (bus.bist_men_o && bus.bist_wen_o)
            mem[bus.bist_addr_o] <= (mem[bus.bist_addr_o] & ~bus.bist_bm_o) | (bus.bist_din_o & bus.bist_bm_o);
        if (bus.bist_men_o && bus.bist_ren_o)
            bus.bist_dout_i <= faulty(mem[bus.bist_addr_o], bus.bist_addr_o);
    end

    // Reference March C- op sequence derived from the op index.
    function automatic void exp_op(input int i, output logic rd, output logic [8:0] a, output logic [31:0] d);
        int j, k, r;
        rd = 1'b0;
        a  = '0;
        d  = '0;
        if (i < 512) begin
            a = 9'(i);
        end else if (i >= 4608) begin
            rd = 1'b1;
            a  = 9'(i - 4608);
        end else begin
            j  = i - 512;
            k  = j / 1024;
            r  = j % 1024;
            rd = ((r % 2) == 0);
            a  = (k >= 2) ? 9'(511 - r / 2) : 9'(r / 2);
            d  = (k == 0 || k == 2) ? 32'hFFFF_FFFF : 32'h0;
        end
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    int          oi;
    int          rd_cnt = 0, wr_cnt = 0, op_err = 0;
    logic        done_q = 1'b0;
    logic        x_rd;
    logic [8:0]  x_a;
    logic [31:0] x_d;
    res_t        er;
    probe_t      ep, ap;

    always @(posedge clk_i) begin
        #1;
        if (run_active) begin
            oi = cyc - e0;
            if (oi == 0) begin
                rd_cnt = 0;
                wr_cnt = 0;
                op_err = 0;
            end
            if (oi >= 0 && oi < 5120) begin
                exp_op(oi, x_rd, x_a, x_d);
                if (bus.bist_men_o && bus.bist_ren_o) rd_cnt++;
                if (bus.bist_men_o && bus.bist_wen_o) wr_cnt++;
                if (!bus.bist_en_o || !bus.bist_men_o || bus.bist_ren_o != x_rd ||
                    bus.bist_wen_o != !x_rd || bus.bist_addr_o != x_a ||
                    (!x_rd && (bus.bist_din_o != x_d || bus.bist_bm_o != 32'hFFFF_FFFF)))
                    op_err++;
            end else if (oi == 5120) begin
                if (!bus.bist_en_o || bus.bist_men_o || bus.bist_wen_o || bus.bist_ren_o) op_err++;
            end else if (oi == 5121) begin
                if (bus.bist_en_o || bus.bist_men_o || bus.bist_wen_o || bus.bist_ren_o) op_err++;
            end
        end
        if (done_o && !done_q) begin
            if (res_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected no completion", cyc);
            end else begin
                er = res_q.pop_front();
                chk("done_latency", cyc - e0, 5121);
                chk("busy_at_done", busy_o, 0);
                chk("pass_o", pass_o, er.pass);
                chk("fail_o", fail_o, er.fail);
                chk("fail_addr_o", fail_addr_o, er.addr);
                chk("fail_elem_o", fail_elem_o, er.elem);
                chk("fail_bits_o", fail_bits_o, er.bits);
                chk("read_count", rd_cnt, 2560);
                chk("write_count", wr_cnt, 2560);
                chk("op_sequence_errors", op_err, 0);
            end
        end
        done_q = done_o;
        if (probe_q.size() != 0) begin
            ep = probe_q.pop_front();
            ap.busy     = busy_o;
            ap.done     = done_o;
            ap.pass     = pass_o;
            ap.fail     = fail_o;
            ap.faddr    = fail_addr_o;
            ap.felem    = fail_elem_o;
            ap.fbits    = fail_bits_o;
            ap.bus_zero = !(bus.bist_en_o || bus.bist_men_o || bus.bist_wen_o || bus.bist_ren_o) &&
                          bus.bist_addr_o == 9'd0 && bus.bist_din_o == 32'd0 && bus.bist_bm_o == 32'd0;
            vectors++;
            if (ap !== ep) begin
                fails++;
                $display("FAIL status_probe: got %h expected %h", ap, ep);
            end
        end
    end

    localparam probe_t P_ZERO    = '{busy: 1'b0, done: 1'b0, pass: 1'b0, fail: 1'b0,
                                     faddr: 9'd0, felem: 3'd0, fbits: 32'd0, bus_zero: 1'b1};
    localparam probe_t P_STARTED = '{busy: 1'b1, done: 1'b0, pass: 1'b0, fail: 1'b0,
                                     faddr: 9'd0, felem: 3'd0, fbits: 32'd0, bus_zero: 1'b0};
    localparam res_t   R_CLEAN   = '{pass: 1'b1, fail: 1'b0, addr: 9'd0, elem: 3'd0, bits: 32'd0};
    localparam res_t   R_SA1     = '{pass: 1'b0, fail: 1'b1, addr: 9'h1A5, elem: 3'd1, bits: 32'h0000_0080};
    localparam res_t   R_SA0     = '{pass: 1'b0, fail: 1'b1, addr: 9'h000, elem: 3'd2, bits: 32'h8000_0000};

    task automatic launch(input int f, input logic hold, input logic push_res, input res_t r);
        @(negedge clk_i);
        fault_mode = f;
        start_i    = 1'b1;
        e0         = cyc + 1;
        run_active = 1'b1;
        if (push_res) res_q.push_back(r);
        probe_q.push_back(P_STARTED);
        if (!hold) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 6000; k++) begin
            @(negedge clk_i);
            if (done_o) break;
        end
        start_i    = 1'b0;
        run_active = 1'b0;
        vectors++;
        if (!done_o) begin
            fails++;
            $display("FAIL done_timeout: got done_o=0 after %0d cycles expected done_o=1", k);
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        probe_q.push_back(P_ZERO);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        probe_q.push_back(P_ZERO);

        launch(0, 1'b0, 1'b1, R_CLEAN);
        wait_done();
        launch(1, 1'b0, 1'b1, R_SA1);
        wait_done();
        // starting from a failed DONE must clear the sticky status at E0
        launch(2, 1'b0, 1'b1, R_SA0);
        wait_done();
        launch(0, 1'b1, 1'b1, R_CLEAN);
        wait_done();

        launch(0, 1'b0, 1'b0, R_CLEAN);
        while (cyc < e0 + 3000) @(negedge clk_i);
        run_active = 1'b0;
        rst_ni     = 1'b0;
        probe_q.push_back(P_ZERO);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        probe_q.push_back(P_ZERO);
        repeat (2) @(negedge clk_i);
        launch(0, 1'b0, 1'b1, R_CLEAN);
        wait_done();

        repeat (3) @(negedge clk_i);
        vectors++;
        if (res_q.size() != 0 || probe_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_expectations: got %0d results and %0d probes pending expected 0",
                     res_q.size(), probe_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
